// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID/EX hazard request and stall/flush response bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 3
);
    logic              ID_valid;
    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic              ID_rs1_used;
    logic              ID_rs2_used;
    logic              EX_valid;
    logic              EX_reg_write;
    logic [REG_AW-1:0] EX_rd;
    logic [CNT_W-1:0]  EX_lat;
    logic              branch_taken;
    logic              MEM_jump;
    logic              stall;
    logic              flush;
    logic              busy;

    modport master (
        output ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
        output EX_valid, EX_reg_write, EX_rd, EX_lat,
        output branch_taken, MEM_jump,
        input  stall, flush, busy
    );

    modport slave (
        input  ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
        input  EX_valid, EX_reg_write, EX_rd, EX_lat,
        input  branch_taken, MEM_jump,
        output stall, flush, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard driving pipeline stall and flush
// Defining HAZARD_SCOREBOARD_STATS_EN adds free-running stall_count/flush_count outputs.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   hz
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
`endif
);
    localparam int NUM_IDX = 2 ** REG_AW;

    logic [CNT_W-1:0]   cnt     [1:NUM_REGS-1];
    logic [CNT_W-1:0]   cnt_nxt [1:NUM_REGS-1];
    logic [NUM_IDX-1:0] pending;
    logic [CNT_W-1:0]   lat_m1;
    logic               issue;
    logic               haz_rs1;
    logic               haz_rs2;

    assign hz.flush = hz.branch_taken | hz.MEM_jump;

    // A wrong-path instruction in EX never reaches the scoreboard.
    assign issue  = hz.EX_valid & hz.EX_reg_write & (hz.EX_rd != '0) &
                    (hz.EX_lat != '0) & ~hz.flush;
    assign lat_m1 = hz.EX_lat - CNT_W'(1);

    // Index space padded to 2^REG_AW so any source index is safe; x0 stays clear.
    always_comb begin
        pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
            // Keep the longer of an older in-flight write and the new one (WAW).
            if (issue && (hz.EX_rd == REG_AW'(r)) && (lat_m1 > cnt_nxt[r])) begin
                cnt_nxt[r] = lat_m1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // The producer issuing this very cycle already blocks its dependent in ID.
    assign haz_rs1 = hz.ID_rs1_used & (hz.ID_rs1 != '0) &
                     (pending[hz.ID_rs1] | (issue & (hz.EX_rd == hz.ID_rs1)));
    assign haz_rs2 = hz.ID_rs2_used & (hz.ID_rs2 != '0) &
                     (pending[hz.ID_rs2] | (issue & (hz.EX_rd == hz.ID_rs2)));

    assign hz.stall = hz.ID_valid & ~hz.flush & (haz_rs1 | haz_rs2);
    assign hz.busy  = |pending;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hz.stall) stall_count <= stall_count + 32'd1;
            if (hz.flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table vectors, corner sequences and randomized reference-model check of hazard_scoreboard
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .CNT_W(3)) bus ();

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    typedef struct {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       exw;
        logic [4:0] rd;
        logic [2:0] lat;
        logic       br;
        logic       jmp;
        logic       es;
        logic       ef;
        logic       eb;
    } vec_t;

    vec_t tbl[$];
    int   vectors;
    int   miscompares;

    // Reference model: the first cycle at which each register may be read again.
    int   ready [32];
    int   t;

    task automatic add(input int idv, input int rs1, input int rs2, input int u1, input int u2,
                       input int exv, input int exw, input int rd, input int lat,
                       input int br, input int jmp, input int es, input int ef, input int eb);
        vec_t v;
        v.idv = idv[0]; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.u1 = u1[0]; v.u2 = u2[0];
        v.exv = exv[0]; v.exw = exw[0]; v.rd = rd[4:0]; v.lat = lat[2:0];
        v.br = br[0]; v.jmp = jmp[0]; v.es = es[0]; v.ef = ef[0]; v.eb = eb[0];
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.ID_valid     = v.idv;
        bus.ID_rs1       = v.rs1;
        bus.ID_rs2       = v.rs2;
        bus.ID_rs1_used  = v.u1;
        bus.ID_rs2_used  = v.u2;
        bus.EX_valid     = v.exv;
        bus.EX_reg_write = v.exw;
        bus.EX_rd        = v.rd;
        bus.EX_lat       = v.lat;
        bus.branch_taken = v.br;
        bus.MEM_jump     = v.jmp;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic id_only(input int rs1, input int u1);
        vec_t v;
        v = '{default: '0};
        v.idv = 1'b1; v.rs1 = rs1[4:0]; v.u1 = u1[0];
        drive(v);
    endtask

    task automatic rand_step(input int n);
        vec_t v;
        logic fl, iss, exp_stall, exp_busy, p1, p2;
        v = '{default: '0};
        v.idv = ($urandom_range(0, 9) != 0);
        v.rs1 = 5'($urandom_range(0, 7));
        v.rs2 = 5'($urandom_range(0, 7));
        v.u1  = $urandom_range(0, 3) != 0;
        v.u2  = $urandom_range(0, 1) != 0;
        v.exv = $urandom_range(0, 2) != 0;
        v.exw = $urandom_range(0, 4) != 0;
        v.rd  = 5'($urandom_range(0, 7));
        v.lat = 3'($urandom_range(0, 7));
        v.br  = $urandom_range(0, 9) == 0;
        v.jmp = $urandom_range(0, 14) == 0;
        drive(v);
        #1;
        fl  = v.br | v.jmp;
        iss = v.exv & v.exw & (v.rd != 0) & (v.lat != 0) & !fl;
        p1  = (v.rs1 != 0) && ((ready[v.rs1] > t) || (iss && v.rd == v.rs1));
        p2  = (v.rs2 != 0) && ((ready[v.rs2] > t) || (iss && v.rd == v.rs2));
        exp_stall = v.idv & !fl & ((v.u1 & p1) | (v.u2 & p2));
        exp_busy  = 1'b0;
        for (int r = 1; r < 32; r++) if (ready[r] > t) exp_busy = 1'b1;
        check($sformatf("rand%0d stall", n), {31'd0, bus.stall}, {31'd0, exp_stall});
        check($sformatf("rand%0d flush", n), {31'd0, bus.flush}, {31'd0, fl});
        check($sformatf("rand%0d busy", n),  {31'd0, bus.busy},  {31'd0, exp_busy});
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check($sformatf("rand%0d stall_count", n), stall_count, 32'(sc));
        check($sformatf("rand%0d flush_count", n), flush_count, 32'(fc));
`endif
        @(posedge clk);
        if (iss && (ready[v.rd] < t + int'(v.lat))) ready[v.rd] = t + int'(v.lat);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        if (exp_stall) sc++;
        if (fl) fc++;
`endif
        t++;
        @(negedge clk);
    endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
    int sc;
    int fc;
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        // load-use
        add(1,5,1,1,1, 1,1,5,1, 0,0, 1,0,0);
        add(1,5,1,1,1, 0,0,0,0, 0,0, 0,0,0);
        // divide, latency 4
        add(1,1,7,1,1, 1,1,7,4, 0,0, 1,0,0);
        for (int i = 0; i < 3; i++) add(1,1,7,1,1, 0,0,0,0, 0,0, 1,0,1);
        add(1,1,7,1,1, 0,0,0,0, 0,0, 0,0,0);
        // x0 destination and unused source
        add(1,0,0,1,0, 1,1,0,1, 0,0, 0,0,0);
        add(1,8,2,0,1, 1,1,8,3, 0,0, 0,0,0);
        add(1,8,2,0,1, 0,0,0,0, 0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0,0, 0,0, 0,0,1);
        // WAW: lat 5 then lat 2 leaves 3 pending
        add(0,9,0,1,0, 1,1,9,5, 0,0, 0,0,0);
        add(1,9,0,1,0, 1,1,9,2, 0,0, 1,0,1);
        for (int i = 0; i < 3; i++) add(1,9,0,1,0, 0,0,0,0, 0,0, 1,0,1);
        add(1,9,0,1,0, 0,0,0,0, 0,0, 0,0,0);
        // flush priority over stall, no counter left behind
        add(1,3,0,1,0, 1,1,3,1, 1,0, 0,1,0);
        add(1,3,0,1,0, 0,0,0,0, 0,0, 0,0,0);
        add(1,0,3,0,1, 1,1,3,3, 0,1, 0,1,0);
        add(1,0,3,0,1, 0,0,0,0, 0,0, 0,0,0);
        // maximum representable latency
        add(1,10,0,1,0, 1,1,10,7, 0,0, 1,0,0);
        for (int i = 0; i < 6; i++) add(1,10,0,1,0, 0,0,0,0, 0,0, 1,0,1);
        add(1,10,0,1,0, 0,0,0,0, 0,0, 0,0,0);

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        check("reset flush", {31'd0, bus.flush}, 32'd0);
        check("reset busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].es});
            check($sformatf("row%0d flush", i), {31'd0, bus.flush}, {31'd0, tbl[i].ef});
            check($sformatf("row%0d busy", i),  {31'd0, bus.busy},  {31'd0, tbl[i].eb});
            @(negedge clk);
        end

        // asynchronous reset in the middle of a countdown on x4
        begin
            vec_t v;
            v = '{default: '0};
            v.exv = 1'b1; v.exw = 1'b1; v.rd = 5'd4; v.lat = 3'd4;
            drive(v);
            @(negedge clk);
            id_only(4, 1);
            #1;
            check("pre-reset stall", {31'd0, bus.stall}, 32'd1);
            check("pre-reset busy",  {31'd0, bus.busy},  32'd1);
            #1 rst_n = 1'b0;
            #1;
            check("async reset stall", {31'd0, bus.stall}, 32'd0);
            check("async reset busy",  {31'd0, bus.busy},  32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("post-reset stall", {31'd0, bus.stall}, 32'd0);
            @(negedge clk);
            #1;
            check("post-reset stall2", {31'd0, bus.stall}, 32'd0);
            check("post-reset busy",   {31'd0, bus.busy},  32'd0);
            @(negedge clk);
        end

        // randomized run against the ready-time model
        rst_n = 1'b0;
        drive_idle();
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 32; r++) ready[r] = 0;
        t = 0;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        sc = 0;
        fc = 0;
`endif
        for (int n = 0; n < 400; n++) rand_step(n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
